uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `uart_transmitter` between `NREQ` byte-producing requesters. It accepts bytes over per-requester valid/ready handshakes and issues one-cycle `tx_start` pulses with the selected byte. It then waits for `tx_done` before arbitrating again. Packet locking keeps multi-byte messages contiguous on the serial line, and a watchdog recovers from a transmitter that never completes.

---
 rtl/uart_tx_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter and sequencer that shares a single UART transmitter
// between NREQ byte producers. A winning byte is captured in ARB, launched
// with a one-cycle tx_start (together with the matching req_ready pulse) in
// ISSUE, and the block then sits in WAIT until the transmitter reports
// tx_done. A byte offered without req_last keeps the packet open (locked), so
// only the same requester may be granted next. A watchdog abandons a frame
// that never completes and raises a sticky timeout_err.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   req_valid[i]    requester i offers a byte (held until its req_ready)
//   req_data        requester i's byte on bits [8i+7:8i]
//   req_last[i]     offered byte closes requester i's packet
//   req_ready[i]    one-cycle one-hot acceptance pulse
//   tx_start        one-cycle launch pulse to the transmitter
//   tx_data         byte for the transmitter, held until the next grant
//   tx_done         completion pulse from the transmitter
//   busy            high while issuing or waiting for a frame
//   grant_id        index of the most recent grant
//   locked          a packet is open
//   timeout_err     sticky watchdog flag
//   err_clr         clears timeout_err (a same-cycle timeout wins)
module uart_tx_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 12000,
    parameter int TO_W           = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic              busy,
    output logic [2:0]        grant_id,
    output logic              locked,
    output logic              timeout_err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] WD_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]      PTR_INIT = 3'(NREQ - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [2:0]        rr_ptr_r;
    logic [TO_W-1:0]   wd_r;
    logic              last_r;
    logic [NREQ-1:0]   elig_s;
    logic              win_s;
    logic [2:0]        win_id_s;
    logic [NREQ-1:0]   win_oh_s;
    logic [7:0]        win_data_s;
    logic              win_last_s;
    logic              timeout_s;

    // Winner selection: mask to the lock owner when a packet is open, then
    // take the first eligible requester after rr_ptr (the owner is always
    // rr_ptr itself while locked, so the same search covers both cases).
    always_comb begin
        elig_s     = {NREQ{1'b0}};
        win_s      = 1'b0;
        win_id_s   = 3'd0;
        win_oh_s   = {NREQ{1'b0}};
        win_data_s = 8'd0;
        win_last_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            elig_s[i] = req_valid[i] & (~locked | (grant_id == 3'(i)));
        end
        for (int k = 1; k <= NREQ; k++) begin
            int   idx_v;
            logic hit_v;
            idx_v = (int'(rr_ptr_r) + k) % NREQ;
            hit_v = elig_s[idx_v] & ~win_s;
            win_oh_s[idx_v] = hit_v;
            win_id_s   = hit_v ? 3'(idx_v) : win_id_s;
            win_data_s = hit_v ? req_data[8*idx_v +: 8] : win_data_s;
            win_last_s = hit_v ? req_last[idx_v] : win_last_s;
            win_s      = win_s | elig_s[idx_v];
        end
    end

    // Next-state logic; tx_done takes precedence over a coincident timeout.
    always_comb begin
        state_nxt_s = state_r;
        timeout_s   = 1'b0;
        case (state_r)
            ST_ARB: begin
                if (win_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    state_nxt_s = ST_ARB;
                end else if (wd_r == WD_LAST) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_ARB;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_ARB;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered outputs, round-robin pointer, captured req_last and watchdog.
    // tx_start/req_ready are set on the ARB->ISSUE edge so they are high
    // exactly during the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready   <= {NREQ{1'b0}};
            tx_start    <= 1'b0;
            tx_data     <= 8'd0;
            busy        <= 1'b0;
            grant_id    <= 3'd0;
            locked      <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr_r    <= PTR_INIT;
            last_r      <= 1'b0;
            wd_r        <= {TO_W{1'b0}};
        end else begin
            req_ready   <= {NREQ{1'b0}};
            tx_start    <= 1'b0;
            timeout_err <= timeout_s | (timeout_err & ~err_clr);
            case (state_r)
                ST_ARB: begin
                    if (win_s) begin
                        tx_data   <= win_data_s;
                        last_r    <= win_last_s;
                        grant_id  <= win_id_s;
                        rr_ptr_r  <= win_id_s;
                        req_ready <= win_oh_s;
                        tx_start  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    wd_r <= {TO_W{1'b0}};
                end
                ST_WAIT: begin
                    wd_r <= wd_r + TO_W'(1);
                    if (tx_done) begin
                        locked <= ~last_r;
                        busy   <= 1'b0;
                    end else if (timeout_s) begin
                        locked <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by a
// randomized traffic phase, all compared each cycle against a transaction
// level model of the arbitration, locking and watchdog rules.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int T  = 20;
    localparam int TW = 5;
    localparam int QD = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic           busy;
    logic [2:0]     grant_id;
    logic           locked;
    logic           timeout_err;
    logic           err_clr;

    uart_tx_arbiter #(.NREQ(N), .TIMEOUT_CYCLES(T), .TO_W(TW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
        .tx_data(tx_data), .tx_done(tx_done), .busy(busy), .grant_id(grant_id),
        .locked(locked), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // requester byte queues: {last, data}
    logic [8:0] qmem [N][QD];
    int qh [N];
    int qt [N];

    // model of the observable behaviour; ph: 0 arbitrating, 1 issuing, 2 waiting
    int         m_ph;
    int         m_ptr;
    int         m_gid;
    logic       m_locked;
    logic       m_err;
    logic       m_last;
    logic [7:0] m_txdata;
    logic       exp_start;
    int         exp_g;
    int         wait_cnt;
    int         cd;
    int         tx_mode;   // 0 random delay, 1 never completes, 2 completes on the timeout cycle
    bit         clr_on_to;
    bit         clr_pulse;
    bit         stray;
    bit         rand_stray;
    bit         rst_req;
    int         glog [16];
    int         gcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int i);
        return qt[i] - qh[i];
    endfunction

    task automatic push(input int i, input logic lst, input logic [7:0] d);
        qmem[i][qt[i] % QD] = {lst, d};
        qt[i]++;
    endtask

    function automatic int pick();
        if (m_locked) return req_valid[m_gid] ? m_gid : -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit idle();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N; i++) if (qsize(i) != 0) e = 1'b0;
        return e && (m_ph == 0) && !exp_start;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_ptr = N - 1; m_gid = 0; m_locked = 1'b0; m_err = 1'b0;
        m_last = 1'b0; m_txdata = 8'd0; exp_start = 1'b0; exp_g = 0;
        wait_cnt = 0; cd = -1;
    endtask

    // One clock: check outputs at the falling edge, retire accepted bytes,
    // drive the next inputs and advance the model to the next rising edge.
    task automatic cycle();
        logic [N-1:0] oh;
        bit to;
        int g;
        @(negedge clk);
        oh = exp_start ? (4'b0001 << exp_g) : 4'b0000;
        chk("tx_start", tx_start, exp_start);
        chk("req_ready", req_ready, oh);
        chk("busy", busy, m_ph != 0);
        chk("locked", locked, m_locked);
        chk("timeout_err", timeout_err, m_err);
        chk("tx_data", tx_data, m_txdata);
        chk("grant_id", grant_id, m_gid);

        if (exp_start) begin
            qh[exp_g]++;
            if (gcnt < 16) glog[gcnt] = exp_g;
            gcnt++;
            case (tx_mode)
                0: cd = int'($urandom_range(1, 8)) + 1;
                2: cd = T + 1;
                default: cd = -1;
            endcase
        end

        tx_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                tx_done = 1'b1;
                cd = -1;
            end
        end
        if (stray || (rand_stray && m_ph != 2 && $urandom_range(0, 7) == 0)) tx_done = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = qsize(i) != 0;
            req_data[8*i +: 8] = req_valid[i] ? qmem[i][qh[i] % QD][7:0] : 8'($urandom);
            req_last[i] = req_valid[i] ? qmem[i][qh[i] % QD][8] : 1'b0;
        end
        err_clr = clr_pulse || (clr_on_to && m_ph == 2 && wait_cnt == T - 1);
        reset = rst_req;

        exp_start = 1'b0;
        to = 1'b0;
        if (rst_req) begin
            model_reset();
        end else begin
            case (m_ph)
                0: begin
                    g = pick();
                    if (g >= 0) begin
                        exp_start = 1'b1; exp_g = g; m_gid = g; m_ptr = g;
                        m_txdata = req_data[8*g +: 8]; m_last = req_last[g]; m_ph = 1;
                    end
                end
                1: begin
                    m_ph = 2; wait_cnt = 0;
                end
                default: begin
                    wait_cnt++;
                    if (tx_done) begin
                        m_locked = !m_last; m_ph = 0;
                    end else if (wait_cnt == T) begin
                        to = 1'b1; m_locked = 1'b0; m_ph = 0;
                    end
                end
            endcase
            m_err = to ? 1'b1 : (err_clr ? 1'b0 : m_err);
        end
    endtask

    task automatic run_idle(input int maxc);
        int n;
        n = 0;
        while (!idle() && n < maxc) begin
            cycle();
            n++;
        end
        checks++;
        assert (idle()) else begin
            errors++;
            $error("FAIL run_idle: still busy after %0d cycles", maxc);
        end
        cycle();
    endtask

    task automatic pulse_reset();
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        gcnt = 0;
    endtask

    initial begin : stim
        int exp_rr [5];
        int exp_lk [4];
        for (int i = 0; i < N; i++) begin
            qh[i] = 0;
            qt[i] = 0;
        end
        tx_mode = 0; clr_on_to = 1'b0; clr_pulse = 1'b0; stray = 1'b0;
        rand_stray = 1'b0; rst_req = 1'b0; gcnt = 0;
        model_reset();
        reset = 1'b1; tx_done = 1'b0; err_clr = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        repeat (3) @(posedge clk);
        pulse_reset();
        cycle();

        // single requester
        push(0, 1'b1, 8'hA5);
        run_idle(100);
        chk("t1_count", gcnt, 1);
        chk("t1_grant", glog[0], 0);
        chk("t1_txdata", tx_data, 8'hA5);

        // round robin from reset
        pulse_reset();
        push(0, 1'b1, 8'h10); push(1, 1'b1, 8'h11); push(2, 1'b1, 8'h12);
        push(3, 1'b1, 8'h13); push(0, 1'b1, 8'h20);
        run_idle(200);
        exp_rr = '{0, 1, 2, 3, 0};
        chk("t2_count", gcnt, 5);
        for (int k = 0; k < 5; k++) chk("t2_order", glog[k], exp_rr[k]);

        // packet lock
        gcnt = 0;
        push(2, 1'b0, 8'hC0); push(2, 1'b0, 8'hC1); push(2, 1'b1, 8'hC2);
        push(0, 1'b1, 8'h0A);
        run_idle(200);
        exp_lk = '{2, 2, 2, 0};
        chk("t3_count", gcnt, 4);
        for (int k = 0; k < 4; k++) chk("t3_order", glog[k], exp_lk[k]);

        // stray tx_done while idle
        gcnt = 0;
        stray = 1'b1;
        cycle();
        stray = 1'b0;
        repeat (4) cycle();
        chk("t4_grants", gcnt, 0);
        chk("t4_busy", busy, 1'b0);

        // watchdog: timeout, set beats clear, clear, done beats timeout
        tx_mode = 1;
        push(1, 1'b0, 8'h55);
        run_idle(100);
        chk("t5_err_set", timeout_err, 1'b1);
        chk("t5_unlocked", locked, 1'b0);
        clr_on_to = 1'b1;
        push(1, 1'b1, 8'h66);
        run_idle(100);
        clr_on_to = 1'b0;
        chk("t5_set_wins", timeout_err, 1'b1);
        clr_pulse = 1'b1;
        cycle();
        clr_pulse = 1'b0;
        cycle();
        chk("t5_cleared", timeout_err, 1'b0);
        tx_mode = 2;
        push(3, 1'b1, 8'h77);
        run_idle(100);
        chk("t5_done_wins", timeout_err, 1'b0);

        // reset in the middle of a frame
        tx_mode = 1;
        push(2, 1'b1, 8'h99);
        for (int n = 0; n < 50 && !(m_ph == 2 && wait_cnt >= 3); n++) cycle();
        checks++;
        assert (m_ph == 2) else begin
            errors++;
            $error("FAIL t6_reach: frame never reached the wait phase");
        end
        push(1, 1'b1, 8'hB1); push(1, 1'b1, 8'hB2); push(0, 1'b1, 8'hB0);
        cycle();
        pulse_reset();
        tx_mode = 0;
        run_idle(200);
        chk("t6_count", gcnt, 3);
        chk("t6_first", glog[0], 0);
        chk("t6_second", glog[1], 1);
        chk("t6_third", glog[2], 1);

        // randomized traffic
        rand_stray = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                int r;
                int len;
                r = int'($urandom_range(0, N - 1));
                len = int'($urandom_range(1, 3));
                if (qsize(r) < 6) begin
                    for (int b = 0; b < len; b++) push(r, b == len - 1, 8'($urandom));
                end
            end
            cycle();
        end
        run_idle(500);
        rand_stray = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
